// File: rtl/snake_pkg.sv
// Shared geometry, state encoding and length clamp for the snake body scanner.
// Wall checking is built only when SNAKE_WALL_CHECK_EN is defined.
package snake_pkg;

  localparam int MAX_LEN = 4;
  localparam int XW      = 8;
  localparam int YW      = 7;
  localparam int SEG     = 10;
  localparam int XSCREEN = 160;
  localparam int YSCREEN = 120;
  localparam int LW      = 3;
  localparam int IW      = $clog2(MAX_LEN);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  // Length 0 still has a head; longer than the store is capped.
  function automatic logic [LW-1:0] eff_len(input logic [LW-1:0] l);
    if (l == '0)
      return LW'(1);
    else if (l > LW'(MAX_LEN))
      return LW'(MAX_LEN);
    else
      return l;
  endfunction

endpackage

// File: rtl/snake_seg_select.sv
// Picks segment idx x/y out of the packed position store.
// Segment 0 (head) occupies the MSBs of each packed bus.
module snake_seg_select
  import snake_pkg::*;
(
  input  logic [IW-1:0]         idx,
  input  logic [XW*MAX_LEN-1:0] x_body,
  input  logic [YW*MAX_LEN-1:0] y_body,
  output logic [XW-1:0]         x_seg,
  output logic [YW-1:0]         y_seg
);

  logic [XW-1:0] xs [MAX_LEN];
  logic [YW-1:0] ys [MAX_LEN];

  // Unpack the store into per-segment fields
  always_comb begin
    for (int i = 0; i < MAX_LEN; i++) begin
      xs[i] = x_body[XW*(MAX_LEN-i)-1 -: XW];
      ys[i] = y_body[YW*(MAX_LEN-i)-1 -: YW];
    end
  end

  assign x_seg = xs[idx];
  assign y_seg = ys[idx];

endmodule

// File: rtl/snake_body_scanner.sv
// Scans stored body segments against the head; flags body/apple hits.
// Optional wall check enabled by defining SNAKE_WALL_CHECK_EN.
module snake_body_scanner
  import snake_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [LW-1:0]         len,
  input  logic [XW*MAX_LEN-1:0] x_body,
  input  logic [YW*MAX_LEN-1:0] y_body,
  input  logic [XW-1:0]         x_apple,
  input  logic [YW-1:0]         y_apple,
  output logic                  busy,
  output logic                  done,
  output logic                  hit_body,
  output logic                  hit_apple,
  output logic                  hit_wall
);

  state_t        state;
  logic [IW-1:0] idx;
  logic [IW-1:0] last;
  logic [XW-1:0] x_head;
  logic [YW-1:0] y_head;
  logic [XW-1:0] x_seg;
  logic [YW-1:0] y_seg;
  logic [XW-1:0] x_new;
  logic [YW-1:0] y_new;
  logic [LW-1:0] eff;

  assign x_new = x_body[XW*MAX_LEN-1 -: XW];
  assign y_new = y_body[YW*MAX_LEN-1 -: YW];
  assign eff   = eff_len(len);

  snake_seg_select u_sel (
    .idx    (idx),
    .x_body (x_body),
    .y_body (y_body),
    .x_seg  (x_seg),
    .y_seg  (y_seg)
  );

  // Scan FSM with registered handshake and hit flags
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      idx       <= '0;
      last      <= '0;
      x_head    <= '0;
      y_head    <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      hit_body  <= 1'b0;
      hit_apple <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            x_head    <= x_new;
            y_head    <= y_new;
            hit_body  <= 1'b0;
            hit_apple <= (x_new == x_apple) && (y_new == y_apple);
            idx       <= IW'(1);
            last      <= IW'(eff - LW'(1));
            busy      <= 1'b1;
            if (eff <= LW'(1)) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state <= SCAN;
            end
          end
        end
        SCAN: begin
          if ((x_seg == x_head) && (y_seg == y_head)) begin
            hit_body <= 1'b1;
            state    <= DONE;
            done     <= 1'b1;
          end else if (idx == last) begin
            state <= DONE;
            done  <= 1'b1;
          end else begin
            idx <= idx + IW'(1);
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          idx   <= '0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef SNAKE_WALL_CHECK_EN
  logic [XW:0] x_end;
  logic [YW:0] y_end;

  assign x_end = {1'b0, x_new} + (XW+1)'(SEG);
  assign y_end = {1'b0, y_new} + (YW+1)'(SEG);

  // Head square past the screen edge, judged at start accept
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      hit_wall <= 1'b0;
    else if ((state == IDLE) && start)
      hit_wall <= (x_end > (XW+1)'(XSCREEN)) ||
                  (y_end > (YW+1)'(YSCREEN));
  end
`else
  assign hit_wall = 1'b0;
`endif

endmodule
